// File: rtl/ex_stage_mul.sv
// ex_stage_mul
// Execute stage sitting directly behind the ID/EX register. Single-cycle ALU
// operations are registered into the EX/MEM output register every cycle.
// MUL/MULHU run on an iterative shift-add multiplier (one multiplier bit per
// cycle). stall_o holds the front of the pipe while that multiplier is busy.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   immediate_data_i      sign-extended immediate
//   read_data_1_i         operand A (rs1)
//   read_data_2_i         rs2 value: operand B when alu_src_i=0, and store data
//   alu_operation_i       4-bit operation code
//   alu_src_i             1 selects immediate_data_i as operand B
//   write_i               instruction writes the register file
//   write_register_i      destination register index
//   flush_i               kill the instruction currently in EX
//   alu_result_o          registered result to MEM
//   read_data_2_o         registered store data
//   write_o               registered write enable
//   write_register_o      registered destination index
//   stall_o               combinational hold request for ID/EX and upstream
module ex_stage_mul #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   immediate_data_i,
  input  logic [XLEN-1:0]   read_data_1_i,
  input  logic [XLEN-1:0]   read_data_2_i,
  input  logic [3:0]        alu_operation_i,
  input  logic              alu_src_i,
  input  logic              write_i,
  input  logic [4:0]        write_register_i,
  input  logic              flush_i,
  output logic [XLEN-1:0]   alu_result_o,
  output logic [XLEN-1:0]   read_data_2_o,
  output logic              write_o,
  output logic [4:0]        write_register_o,
  output logic              stall_o
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_PASS  = 4'd12;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);
  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nx_s;

  logic [XLEN-1:0]      operand_b_s;
  logic [SHW-1:0]       shamt_s;
  logic [XLEN-1:0]      alu_result_s;
  logic                 is_mul_s;

  logic                 start_mul_s;
  logic                 load_prod_s;
  logic                 mul_step_s;

  logic [XLEN-1:0]      mcand_r;      // multiplicand (operand A)
  logic [XLEN-1:0]      mplier_r;     // multiplier (operand B)
  logic                 mul_hi_r;     // 1: MULHU, return upper half
  logic [2*XLEN-1:0]    acc_r;
  logic [2*XLEN-1:0]    acc_nx_s;
  logic [2*XLEN-1:0]    partial_s;
  logic [SHW-1:0]       cnt_r;

  // Operand B select and multiply-op decode.
  always_comb begin
    if (alu_src_i) begin
      operand_b_s = immediate_data_i;
    end else begin
      operand_b_s = read_data_2_i;
    end
    shamt_s  = operand_b_s[SHW-1:0];
    is_mul_s = (alu_operation_i == OP_MUL) || (alu_operation_i == OP_MULHU);
  end

  // Single-cycle ALU; unused codes (and the multiply codes) give 0.
  always_comb begin
    alu_result_s = {XLEN{1'b0}};
    case (alu_operation_i)
      OP_ADD:  alu_result_s = read_data_1_i + operand_b_s;
      OP_SUB:  alu_result_s = read_data_1_i - operand_b_s;
      OP_AND:  alu_result_s = read_data_1_i & operand_b_s;
      OP_OR:   alu_result_s = read_data_1_i | operand_b_s;
      OP_XOR:  alu_result_s = read_data_1_i ^ operand_b_s;
      OP_SLL:  alu_result_s = read_data_1_i << shamt_s;
      OP_SRL:  alu_result_s = read_data_1_i >> shamt_s;
      OP_SRA:  alu_result_s = $unsigned($signed(read_data_1_i) >>> shamt_s);
      OP_SLT:  alu_result_s = {{(XLEN-1){1'b0}},
                               ($signed(read_data_1_i) < $signed(operand_b_s))};
      OP_SLTU: alu_result_s = {{(XLEN-1){1'b0}}, (read_data_1_i < operand_b_s)};
      OP_PASS: alu_result_s = operand_b_s;
      default: alu_result_s = {XLEN{1'b0}};
    endcase
  end

  // Shift-add step: add the multiplicand shifted by the current bit position.
  always_comb begin
    partial_s = {{XLEN{1'b0}}, mcand_r} << cnt_r;
    if (mplier_r[cnt_r]) begin
      acc_nx_s = acc_r + partial_s;
    end else begin
      acc_nx_s = acc_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic; flush always returns to IDLE.
  always_comb begin
    state_nx_s = state_r;
    if (flush_i) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (is_mul_s) begin
            state_nx_s = ST_BUSY;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cnt_r == CNT_LAST) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_BUSY;
          end
        end
        ST_DONE: state_nx_s = ST_IDLE;
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: stall request and multiplier/output-register controls.
  always_comb begin
    stall_o     = 1'b0;
    start_mul_s = 1'b0;
    load_prod_s = 1'b0;
    mul_step_s  = 1'b0;
    if (flush_i) begin
      stall_o = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (is_mul_s) begin
            stall_o     = 1'b1;
            start_mul_s = 1'b1;
          end else begin
            stall_o     = 1'b0;
          end
        end
        ST_BUSY: begin
          stall_o    = 1'b1;
          mul_step_s = 1'b1;
        end
        ST_DONE: load_prod_s = 1'b1;
        default: stall_o     = 1'b0;
      endcase
    end
  end

  // Multiplier datapath: operand capture, accumulator and bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_r  <= {XLEN{1'b0}};
      mplier_r <= {XLEN{1'b0}};
      mul_hi_r <= 1'b0;
      acc_r    <= {(2*XLEN){1'b0}};
      cnt_r    <= {SHW{1'b0}};
    end else if (start_mul_s) begin
      mcand_r  <= read_data_1_i;
      mplier_r <= operand_b_s;
      mul_hi_r <= (alu_operation_i == OP_MULHU);
      acc_r    <= {(2*XLEN){1'b0}};
      cnt_r    <= {SHW{1'b0}};
    end else if (mul_step_s) begin
      acc_r    <= acc_nx_s;
      cnt_r    <= cnt_r + CNT_ONE;
    end else begin
      acc_r    <= acc_r;
      cnt_r    <= cnt_r;
    end
  end

  // EX/MEM output register: bubble while stalled or flushed, product in DONE,
  // ALU result otherwise. Write fields in DONE come from the held ID/EX inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_result_o     <= {XLEN{1'b0}};
      read_data_2_o    <= {XLEN{1'b0}};
      write_o          <= 1'b0;
      write_register_o <= 5'd0;
    end else if (flush_i || stall_o) begin
      alu_result_o     <= {XLEN{1'b0}};
      read_data_2_o    <= {XLEN{1'b0}};
      write_o          <= 1'b0;
      write_register_o <= 5'd0;
    end else if (load_prod_s) begin
      if (mul_hi_r) begin
        alu_result_o <= acc_r[2*XLEN-1:XLEN];
      end else begin
        alu_result_o <= acc_r[XLEN-1:0];
      end
      read_data_2_o    <= read_data_2_i;
      write_o          <= write_i;
      write_register_o <= write_register_i;
    end else begin
      alu_result_o     <= alu_result_s;
      read_data_2_o    <= read_data_2_i;
      write_o          <= write_i;
      write_register_o <= write_register_i;
    end
  end

endmodule

// File: tb/tb_ex_stage_mul.sv
// Directed testbench for ex_stage_mul: reset, back-to-back ALU ops, iterative
// multiply timing/results, flush and reset abort of multiplies.
module tb_ex_stage_mul;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] immediate_data_i;
  logic [31:0] read_data_1_i;
  logic [31:0] read_data_2_i;
  logic [3:0]  alu_operation_i;
  logic        alu_src_i;
  logic        write_i;
  logic [4:0]  write_register_i;
  logic        flush_i;
  logic [31:0] alu_result_o;
  logic [31:0] read_data_2_o;
  logic        write_o;
  logic [4:0]  write_register_o;
  logic        stall_o;

  int n_vec = 0;
  int n_err = 0;

  ex_stage_mul #(.XLEN(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .immediate_data_i (immediate_data_i),
    .read_data_1_i    (read_data_1_i),
    .read_data_2_i    (read_data_2_i),
    .alu_operation_i  (alu_operation_i),
    .alu_src_i        (alu_src_i),
    .write_i          (write_i),
    .write_register_i (write_register_i),
    .flush_i          (flush_i),
    .alu_result_o     (alu_result_o),
    .read_data_2_o    (read_data_2_o),
    .write_o          (write_o),
    .write_register_o (write_register_o),
    .stall_o          (stall_o)
  );

  always #5 clk = ~clk;

  // ALU vector table: op, A, rs2, imm, alu_src, expected result
  localparam int NV = 12;
  localparam logic [3:0]  V_OP  [NV] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd9, 4'd2,
                                         4'd3, 4'd4, 4'd5, 4'd6, 4'd12, 4'd14};
  localparam logic [31:0] V_A   [NV] = '{32'd5, 32'd3, 32'h80000000, 32'hFFFFFFFF,
                                         32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0F00000,
                                         32'hFFFF0000, 32'd1, 32'h80000000,
                                         32'h0000DEAD, 32'd7};
  localparam logic [31:0] V_B   [NV] = '{32'hFFFFFFFF, 32'd5, 32'h00001234, 32'd1,
                                         32'd1, 32'h0FF00FF0, 32'h00000F0F,
                                         32'h0F0F0F0F, 32'h00000023, 32'h00005555,
                                         32'h00000011, 32'd9};
  localparam logic [31:0] V_IMM [NV] = '{32'd0, 32'd0, 32'd4, 32'd0, 32'd0, 32'd0,
                                         32'd0, 32'd0, 32'd0, 32'd31, 32'h00000ABC,
                                         32'd0};
  localparam logic        V_SRC [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [31:0] V_EXP [NV] = '{32'd4, 32'hFFFFFFFE, 32'hF8000000, 32'd1,
                                         32'd0, 32'h00F000F0, 32'hF0F00F0F,
                                         32'hF0F00F0F, 32'd8, 32'd1, 32'h00000ABC,
                                         32'd0};

  task automatic drive(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm,
                       input logic src, input logic w, input logic [4:0] rd);
    alu_operation_i  = op;
    read_data_1_i    = a;
    read_data_2_i    = b;
    immediate_data_i = imm;
    alu_src_i        = src;
    write_i          = w;
    write_register_i = rd;
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    flush_i = 1'b0;
    drive(4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 5'd3);
    #12;
    n_vec++;
    if ({alu_result_o, read_data_2_o, write_o, write_register_o} !== 70'd0) begin
      n_err++;
      $display("FAIL reset_init: got %h/%h/%b/%0d expected all zero",
               alu_result_o, read_data_2_o, write_o, write_register_o);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (alu_result_o !== 32'd12 || write_o !== 1'b1 || write_register_o !== 5'd3) begin
      n_err++;
      $display("FAIL pre_reset_add: got %h w=%b rd=%0d expected 0000000c w=1 rd=3",
               alu_result_o, write_o, write_register_o);
    end
    #3 reset = 1'b1;
    #1;
    n_vec++;
    if ({alu_result_o, read_data_2_o, write_o, write_register_o} !== 70'd0) begin
      n_err++;
      $display("FAIL reset_mid: got %h/%h/%b/%0d expected all zero",
               alu_result_o, read_data_2_o, write_o, write_register_o);
    end
    @(posedge clk); #1 reset = 1'b0;
    #1;
    n_vec++;
    if (stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_stall: got %b expected 0", stall_o);
    end
  endtask

  task automatic test_alu_back_to_back;
    for (int i = 0; i < NV; i++) begin
      drive(V_OP[i], V_A[i], V_B[i], V_IMM[i], V_SRC[i], (i % 2) == 0, 5'(i + 1));
      #1;
      n_vec++;
      if (stall_o !== 1'b0) begin
        n_err++;
        $display("FAIL alu_stall[%0d]: got %b expected 0", i, stall_o);
      end
      @(posedge clk); #1;
      n_vec++;
      if (alu_result_o !== V_EXP[i] || read_data_2_o !== V_B[i] ||
          write_o !== ((i % 2) == 0) || write_register_o !== 5'(i + 1)) begin
        n_err++;
        $display("FAIL alu[%0d] op=%0d: got res=%h rs2=%h w=%b rd=%0d expected res=%h rs2=%h w=%b rd=%0d",
                 i, V_OP[i], alu_result_o, read_data_2_o, write_o, write_register_o,
                 V_EXP[i], V_B[i], (i % 2) == 0, i + 1);
      end
    end
  endtask

  task automatic test_mul(input string name, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp);
    int cyc;
    drive(op, a, b, 32'd0, 1'b0, 1'b1, rd);
    #1;
    n_vec++;
    if (stall_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s_stall0: got %b expected 1", name, stall_o);
    end
    cyc = 0;
    while (stall_o === 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      n_vec++;
      if (alu_result_o !== 32'd0 || read_data_2_o !== 32'd0 ||
          write_o !== 1'b0 || write_register_o !== 5'd0) begin
        n_err++;
        $display("FAIL %s_bubble@%0d: got %h/%h/%b/%0d expected all zero",
                 name, cyc, alu_result_o, read_data_2_o, write_o, write_register_o);
      end
    end
    n_vec++;
    if (cyc !== 33) begin
      n_err++;
      $display("FAIL %s_stall_len: got %0d expected 33", name, cyc);
    end
    @(posedge clk); #1;
    n_vec++;
    if (alu_result_o !== exp || write_o !== 1'b1 || write_register_o !== rd ||
        read_data_2_o !== b) begin
      n_err++;
      $display("FAIL %s_result: got res=%h w=%b rd=%0d rs2=%h expected res=%h w=1 rd=%0d rs2=%h",
               name, alu_result_o, write_o, write_register_o, read_data_2_o, exp, rd, b);
    end
    drive(4'd13, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
  endtask

  // Idle for a window checking that nothing stalls or writes.
  task automatic quiet_window(input string name);
    int bad;
    bad = 0;
    drive(4'd13, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (stall_o !== 1'b0 || write_o !== 1'b0 || alu_result_o !== 32'd0) bad++;
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL %s_quiet: got %0d bad cycles (last stall=%b w=%b res=%h) expected 0",
               name, bad, stall_o, write_o, alu_result_o);
    end
  endtask

  task automatic test_flush_mid_mul;
    drive(4'd10, 32'd3, 32'd5, 32'd0, 1'b0, 1'b1, 5'd9);
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
    end
    n_vec++;
    if (stall_o !== 1'b1) begin
      n_err++;
      $display("FAIL flush_mid_prestall: got %b expected 1", stall_o);
    end
    flush_i = 1'b1;
    #1;
    n_vec++;
    if (stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush_mid_stall: got %b expected 0", stall_o);
    end
    @(posedge clk); #1;
    n_vec++;
    if (write_o !== 1'b0 || alu_result_o !== 32'd0 || write_register_o !== 5'd0) begin
      n_err++;
      $display("FAIL flush_mid_bubble: got res=%h w=%b rd=%0d expected all zero",
               alu_result_o, write_o, write_register_o);
    end
    flush_i = 1'b0;
    drive(4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 5'd4);
    #1;
    n_vec++;
    if (stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush_mid_add_stall: got %b expected 0", stall_o);
    end
    @(posedge clk); #1;
    n_vec++;
    if (alu_result_o !== 32'd3 || write_o !== 1'b1 || write_register_o !== 5'd4) begin
      n_err++;
      $display("FAIL flush_mid_add: got res=%h w=%b rd=%0d expected 00000003 w=1 rd=4",
               alu_result_o, write_o, write_register_o);
    end
    quiet_window("flush_mid");
  endtask

  task automatic test_flush_idle_mul;
    flush_i = 1'b1;
    drive(4'd10, 32'd3, 32'd5, 32'd0, 1'b0, 1'b1, 5'd9);
    #1;
    n_vec++;
    if (stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle_stall: got %b expected 0", stall_o);
    end
    @(posedge clk); #1;
    n_vec++;
    if (write_o !== 1'b0 || alu_result_o !== 32'd0) begin
      n_err++;
      $display("FAIL flush_idle_bubble: got res=%h w=%b expected 0 w=0",
               alu_result_o, write_o);
    end
    flush_i = 1'b0;
    quiet_window("flush_idle");
  endtask

  task automatic test_reset_busy;
    drive(4'd10, 32'd3, 32'd5, 32'd0, 1'b0, 1'b1, 5'd9);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    #3;
    reset = 1'b1;
    drive(4'd13, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    #1;
    n_vec++;
    if ({alu_result_o, read_data_2_o, write_o, write_register_o} !== 70'd0 ||
        stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy: got res=%h w=%b stall=%b expected all zero",
               alu_result_o, write_o, stall_o);
    end
    @(posedge clk); #1 reset = 1'b0;
    quiet_window("reset_busy");
  endtask

  initial begin
    test_reset();
    test_alu_back_to_back();
    test_mul("mul_lo",   4'd10, 32'h00010000, 32'h00010000, 5'd7, 32'h00000000);
    test_mul("mulhu",    4'd11, 32'h00010000, 32'h00010000, 5'd7, 32'h00000001);
    test_mul("mulhu_max", 4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'hFFFFFFFE);
    test_mul("mul_max",  4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'h00000001);
    test_flush_mid_mul();
    test_flush_idle_mul();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage_mul.md
# ex_stage_mul

Execute stage placed directly downstream of the ID/EX pipeline register. It consumes the decoded operands, immediate, 4-bit ALU operation and write-back tag, and computes single-cycle ALU results. Multiplies run on an iterative shift-add unit while the front of the pipe is stalled. Results land in an internal EX/MEM output register that feeds the memory stage.

## Interface
- XLEN, 32, datapath width; multiply iterations = XLEN; shift amount = operand B[log2(XLEN)-1:0]
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state and outputs
- immediate_data_i  input  XLEN  sign-extended immediate from ID/EX
- read_data_1_i  input  XLEN  operand A (rs1 value)
- read_data_2_i  input  XLEN  rs2 value; operand B when alu_src_i=0; store data
- alu_operation_i  input  4  operation code (see Operation)
- alu_src_i  input  1  0: operand B = read_data_2_i; 1: operand B = immediate_data_i
- write_i  input  1  instruction writes the register file
- write_register_i  input  5  destination register index
- flush_i  input  1  synchronous kill of the instruction currently in EX
- alu_result_o  output  XLEN  registered result to MEM
- read_data_2_o  output  XLEN  registered rs2 value (store data)
- write_o  output  1  registered write enable
- write_register_o  output  5  registered destination index
- stall_o  output  1  combinational; 1 = ID/EX and upstream stages must hold

## Operation
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA
  - 8 SLT (signed), 9 SLTU, 12 PASS (result = operand B)
  - 10 MUL (low XLEN bits of unsigned product), 11 MULHU (high XLEN bits)
  - 13–15 give result 0; write_i and write_register_i still pass through unchanged
- Arithmetic wraps modulo 2^XLEN. SLT and SLTU return 0 or 1, zero-extended.
- FSM states and transitions:
  - IDLE:
    - non-multiply op: the EX/MEM register loads the ALU result, read_data_2_i, write_i and write_register_i each cycle
    - multiply op with flush_i=0: latch A, B and the op, clear the 2·XLEN accumulator, set counter=0, go to BUSY
  - BUSY: each cycle, if multiplier bit[counter]=1, add the multiplicand shifted by counter. Counter increments. After the XLEN-th iteration, go to DONE.
  - DONE: load the product half selected by the op into alu_result_o, and load the write fields from the current inputs (still held by ID/EX). Go to IDLE unconditionally; DONE never re-triggers a multiply.
- stall_o = ~flush_i & ((IDLE & multiply op) | BUSY).
- While stall_o=1, the EX/MEM register loads a bubble: all four outputs 0.
- flush_i=1 in any state:
  - go to IDLE and load a bubble next edge
  - an in-flight multiply is discarded
  - a multiply op arriving with flush in IDLE does not start
- The reset value of every output and internal register is 0; the state resets to IDLE.
- Reset mid-multiply aborts immediately. No result or write is ever emitted for the aborted op.

## Timing
- Non-multiply: inputs at edge N → outputs valid after edge N+1 (1-cycle latency), one instruction per cycle.
- Multiply presented in cycle 0 (IDLE):
  - stall_o is high in cycles 0..XLEN, i.e. XLEN+1 = 33 cycles for XLEN=32
  - DONE is cycle XLEN+1, with stall_o=0
  - result and write fields are visible on the outputs after the edge ending the DONE cycle (34 edges for XLEN=32)
  - the next instruction enters EX in cycle XLEN+2
- Outputs during the stall cycles are bubbles, so MEM/WB see write_o=0.
- stall_o depends only on the state, alu_operation_i and flush_i; there is no path from the outputs.

## Test plan
- Reset: assert reset mid-cycle with nonzero inputs → all outputs 0 immediately, stall_o=0 after release.
- ALU back-to-back:
  - ADD A=5, B=0xFFFFFFFF, alu_src=0 → 4
  - SUB 3−5 → 0xFFFFFFFE
  - SRA 0x80000000 by imm=4 (alu_src=1) → 0xF8000000
  - SLT −1<1 → 1
  - SLTU 0xFFFFFFFF<1 → 0
  - each result appears one cycle after its input, with write_o and write_register_o following the inputs
- Multiply: MUL 0x10000×0x10000, write_register=7 → stall_o high 33 cycles, bubbles meanwhile, then alu_result_o=0x00000000 with write_o=1 and write_register_o=7. MULHU of the same operands → 0x00000001.
- Boundary product: MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE, and MUL of the same operands → 0x00000001.
- Flush mid-multiply: flush_i=1 at BUSY iteration 10 → stall_o drops that cycle, next output is a bubble, and the following ADD completes normally.
- Flush with multiply in IDLE, and reset in BUSY → no multiply starts and no stall, and no result or write is ever emitted.
